dpi_pkt_sequencer: RTL and testbench
====================================

# dpi_pkt_sequencer

Front-end scheduler for the DPI regex-match array. It takes the tagged packet byte stream from the ingress parser and sequences each packet through the shared per-regex matcher wrappers: restore stream state, stream the characters, then finalize with end-of-packet once the last match has settled. It also owns the 64-entry stream-seen bitmap that drives `new_stream_id`, and the per-stream regex enable masks.

## Interface
- `NUM_REGEX`, default 16: number of matcher wrappers; width of the enable masks.
- `MATCH_LAT`, default 1: matcher latency in cycles, from char presented to `accept_out`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: ingress beat valid.
- `in_ready` out 1: ingress beat accepted when `in_valid & in_ready`.
- `in_data` in 8: packet byte.
- `in_sop` in 1: first byte of packet.
- `in_eop` in 1: last byte of packet.
- `in_stream_id` in 6: stream tag; meaningful only with `in_sop`.
- `cfg_we` in 1: write enable for the enable-mask table.
- `cfg_stream` in 6: table index for `cfg_we`.
- `cfg_mask` in NUM_REGEX: enable mask written by `cfg_we`.
- `flush` in 1: pulse; clears the seen bitmap.
- `m_load_state` out 1: restore pulse to the matchers.
- `m_new_stream_id` out 1: stream not seen since reset or flush.
- `m_stream_id` out 6: current stream.
- `m_char` out 8: character to the matchers.
- `m_char_vld` out 1: `m_char` is valid.
- `m_eop` out 1: finalize pulse.
- `m_enable` out NUM_REGEX: per-regex enable for the current packet.
- `busy` out 1: packet in flight (state ≠ IDLE).
- `err_orphan` out 1: pulse; a non-SOP beat arrived in IDLE and was dropped.
- `stat_pkts` out 32, `stat_bytes` out 32: statistics counters (see Configuration).

## Operation
- FSM states: IDLE, LOAD, PRIME, STREAM, DRAIN, FIN.
- IDLE
  - `in_valid & in_sop`: latch `in_stream_id`, go to LOAD. The beat is not consumed.
  - `in_valid & ~in_sop`: `in_ready`=1, beat dropped, `err_orphan` pulses.
- LOAD, one cycle
  - `m_load_state`=1; `m_new_stream_id` = ~seen[id].
  - Set seen[id]; latch `m_enable` = mask[id].
- PRIME, one cycle: lets the wrapper apply `state_in_vld`. No characters are issued.
- STREAM
  - `in_ready`=1. Each accepted beat is registered onto `m_char`/`m_char_vld` the next cycle.
  - An `in_sop` on a non-first beat is treated as data.
  - The accepted beat with `in_eop` moves to DRAIN.
- DRAIN: waits `MATCH_LAT` cycles, then moves to FIN.
- FIN, one cycle: `m_eop`=1, then IDLE.
- `m_stream_id` and `m_enable` are held stable from LOAD through FIN.
- Enable-mask table: 64×NUM_REGEX registers.
  - Writes take effect at the next LOAD.
  - A write to the active stream does not change the in-flight `m_enable`.
- `flush`
  - In IDLE: clears the bitmap immediately.
  - Otherwise: recorded and applied on entry to IDLE.
  - `flush` coinciding with a LOAD: the LOAD's set of seen[id] wins; the flush is deferred and clears it at IDLE.
- `cfg_we` is honoured in every state.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - Seen bitmap cleared; masks all zero; flush-pending cleared; stats 0.
  - Reset mid-packet abandons the packet; no `m_eop` is issued.
- SOP seen in IDLE at cycle T:
  - LOAD at T+1; PRIME at T+2; STREAM from T+3.
  - First beat can be accepted at T+3; its char appears at T+4.
- Last char presented at cycle c: `m_eop` at c+MATCH_LAT+1; IDLE at c+MATCH_LAT+2.
- Next SOP is evaluated in the first IDLE cycle.
  - Packet overhead: 3 cycles before data, MATCH_LAT+2 cycles after the last accepted beat.
- Single-byte packet (`in_sop & in_eop`): accepted at T+3, char at T+4, `m_eop` at T+5+MATCH_LAT.
- `in_valid` gaps in STREAM hold `m_char_vld` low; no timeout.

## Configuration
- `DPI_SEQ_STATS_EN` defined:
  - `stat_pkts` increments in FIN.
  - `stat_bytes` increments per accepted STREAM beat.
  - Both wrap at 2^32; both clear on reset only.
- `DPI_SEQ_STATS_EN` undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Shared package `dpi_pkg`:
  - FSM state enum.
  - `STREAM_ID_W`=6.
  - `NUM_STREAMS`=64.
- Sub-module `dpi_stream_table`: seen bitmap, enable-mask registers, and flush-pending logic.
  - Read and test-and-set port for LOAD; write port for cfg.

## Test plan
- Reset; cfg mask[5]=16'h0003; 4-byte packet on stream 5 → `m_load_state` at T+1 with `m_new_stream_id`=1 and `m_enable`=16'h0003; 4 chars T+4..T+7; `m_eop` at T+9.
- Second packet on stream 5 → `m_new_stream_id`=0. `flush` in IDLE, then stream 5 again → `m_new_stream_id`=1.
- Single-byte packet on stream 63, MATCH_LAT=3 → exactly one `m_char_vld`; `m_eop` 4 cycles after it.
- Non-SOP beat (data 8'hAA) in IDLE → dropped; `err_orphan`=1 for one cycle; no `m_char_vld`.
- `cfg_we` to the active stream mid-STREAM, and `flush` mid-STREAM:
  - `m_enable` unchanged until FIN.
  - The next packet uses the new mask.
  - seen is cleared at IDLE, so the next packet on the same stream gives `m_new_stream_id`=1.
- `rst_n` low during STREAM → all outputs 0, no `m_eop`, state IDLE. With STATS_EN, stats are 0; after 3 packets of 10 bytes, `stat_pkts`=3 and `stat_bytes`=30.

Source files
------------

// File: rtl/dpi_pkg.sv
// Shared types and constants for the DPI packet sequencer slice.
package dpi_pkg;

  localparam int unsigned STREAM_ID_W = 6;
  localparam int unsigned NUM_STREAMS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRIME,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } seq_state_e;

endpackage

// File: rtl/dpi_stream_table.sv
// Per-stream state: seen bitmap with deferred flush, and the regex enable-mask registers.
module dpi_stream_table
  import dpi_pkg::*;
#(
  parameter int unsigned NUM_REGEX = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [STREAM_ID_W-1:0] lookup_id,
  output logic                   lookup_seen_c,
  output logic [NUM_REGEX-1:0]   lookup_mask_c,
  input  logic                   set_en,
  input  logic [STREAM_ID_W-1:0] set_id,
  input  logic                   flush,
  input  logic                   idle,
  input  logic                   idle_entry,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_stream,
  input  logic [NUM_REGEX-1:0]   cfg_mask
);

  logic [NUM_STREAMS-1:0] seen_q, seen_d;
  logic [NUM_REGEX-1:0]   mask_q [NUM_STREAMS];
  logic [NUM_REGEX-1:0]   mask_d [NUM_STREAMS];
  logic                   flush_pend_q, flush_pend_d;
  logic                   clear_c;

  // Same-cycle flush and cfg write are forwarded so the lookup sees them.
  always_comb begin
    lookup_seen_c = seen_q[lookup_id] & ~(flush & idle);
    lookup_mask_c = (cfg_we && (cfg_stream == lookup_id)) ? cfg_mask : mask_q[lookup_id];
  end

  always_comb begin
    clear_c      = (flush & idle) | (idle_entry & (flush_pend_q | flush));
    flush_pend_d = flush_pend_q;
    seen_d       = seen_q;
    mask_d       = mask_q;
    if (clear_c) begin
      flush_pend_d = 1'b0;
      seen_d       = '0;
    end else if (flush) begin
      flush_pend_d = 1'b1;
    end
    if (set_en) begin
      seen_d[set_id] = 1'b1;
    end
    if (cfg_we) begin
      mask_d[cfg_stream] = cfg_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q       <= '0;
      flush_pend_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
        mask_q[i] <= '0;
      end
    end else begin
      seen_q       <= seen_d;
      flush_pend_q <= flush_pend_d;
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
        mask_q[i] <= mask_d[i];
      end
    end
  end

endmodule

// File: rtl/dpi_pkt_sequencer.sv
// Sequences tagged packets through the regex matcher array: restore, stream, drain, finalize.
// Optional statistics counters are built when DPI_SEQ_STATS_EN is defined.
module dpi_pkt_sequencer
  import dpi_pkg::*;
#(
  parameter int unsigned NUM_REGEX = 16,
  parameter int unsigned MATCH_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [STREAM_ID_W-1:0] in_stream_id,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_stream,
  input  logic [NUM_REGEX-1:0]   cfg_mask,
  input  logic                   flush,
  output logic                   m_load_state,
  output logic                   m_new_stream_id,
  output logic [STREAM_ID_W-1:0] m_stream_id,
  output logic [7:0]             m_char,
  output logic                   m_char_vld,
  output logic                   m_eop,
  output logic [NUM_REGEX-1:0]   m_enable,
  output logic                   busy,
  output logic                   err_orphan,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_bytes
);

  localparam int unsigned DRAIN_W = $clog2(MATCH_LAT + 1) + 1;

  seq_state_e             state_q, state_d;
  logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [STREAM_ID_W-1:0] stream_id_q, stream_id_d;
  logic [NUM_REGEX-1:0]   enable_q, enable_d;
  logic                   new_id_q, new_id_d;
  logic [7:0]             char_q, char_d;
  logic                   char_vld_q, char_vld_d;
  logic                   load_q, load_d;
  logic                   eop_q, eop_d;
  logic                   busy_q, busy_d;
  logic                   orphan_q, orphan_d;
  logic                   lookup_seen_c;
  logic [NUM_REGEX-1:0]   lookup_mask_c;
  logic                   accept_c;

  assign in_ready = (state_q == ST_STREAM) | ((state_q == ST_IDLE) & in_valid & ~in_sop);
  assign accept_c = (state_q == ST_STREAM) & in_valid;

  dpi_stream_table #(
    .NUM_REGEX (NUM_REGEX)
  ) u_table (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_id     (in_stream_id),
    .lookup_seen_c (lookup_seen_c),
    .lookup_mask_c (lookup_mask_c),
    .set_en        (state_q == ST_LOAD),
    .set_id        (stream_id_q),
    .flush         (flush),
    .idle          (state_q == ST_IDLE),
    .idle_entry    (state_q == ST_FIN),
    .cfg_we        (cfg_we),
    .cfg_stream    (cfg_stream),
    .cfg_mask      (cfg_mask)
  );

  // Next state; packet context is captured on the IDLE->LOAD edge and held to FIN.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stream_id_d = stream_id_q;
    enable_d    = enable_q;
    new_id_d    = new_id_q;
    char_d      = char_q;
    char_vld_d  = 1'b0;
    orphan_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_sop) begin
          state_d     = ST_LOAD;
          stream_id_d = in_stream_id;
          enable_d    = lookup_mask_c;
          new_id_d    = ~lookup_seen_c;
        end else if (in_valid) begin
          orphan_d = 1'b1;
        end
      end
      ST_LOAD:  state_d = ST_PRIME;
      ST_PRIME: state_d = ST_STREAM;
      ST_STREAM: begin
        if (in_valid) begin
          char_d     = in_data;
          char_vld_d = 1'b1;
          if (in_eop) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(MATCH_LAT)) begin
          state_d = ST_FIN;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    load_d = (state_d == ST_LOAD);
    eop_d  = (state_d == ST_FIN);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      stream_id_q <= '0;
      enable_q    <= '0;
      new_id_q    <= 1'b0;
      char_q      <= '0;
      char_vld_q  <= 1'b0;
      load_q      <= 1'b0;
      eop_q       <= 1'b0;
      busy_q      <= 1'b0;
      orphan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stream_id_q <= stream_id_d;
      enable_q    <= enable_d;
      new_id_q    <= new_id_d;
      char_q      <= char_d;
      char_vld_q  <= char_vld_d;
      load_q      <= load_d;
      eop_q       <= eop_d;
      busy_q      <= busy_d;
      orphan_q    <= orphan_d;
    end
  end

  assign m_load_state    = load_q;
  assign m_new_stream_id = new_id_q;
  assign m_stream_id     = stream_id_q;
  assign m_char          = char_q;
  assign m_char_vld      = char_vld_q;
  assign m_eop           = eop_q;
  assign m_enable        = enable_q;
  assign busy            = busy_q;
  assign err_orphan      = orphan_q;

`ifdef DPI_SEQ_STATS_EN
  logic [31:0] stat_pkts_q, stat_pkts_d;
  logic [31:0] stat_bytes_q, stat_bytes_d;

  always_comb begin
    stat_pkts_d  = stat_pkts_q + 32'(state_q == ST_FIN);
    stat_bytes_d = stat_bytes_q + 32'(accept_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_pkts_q  <= '0;
      stat_bytes_q <= '0;
    end else begin
      stat_pkts_q  <= stat_pkts_d;
      stat_bytes_q <= stat_bytes_d;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_bytes = stat_bytes_q;
`else
  logic unused_accept;
  assign unused_accept = accept_c;
  assign stat_pkts     = '0;
  assign stat_bytes    = '0;
`endif

endmodule

// File: tb/tb_dpi_pkt_sequencer.sv
// Randomized bench for dpi_pkt_sequencer: packet schedules from the timing rules feed a per-cycle scoreboard.
module tb_dpi_pkt_sequencer;

  localparam int NR  = 16;
  localparam int LAT = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, in_sop, in_eop;
  logic [7:0]    in_data;
  logic [5:0]    in_stream_id;
  logic          cfg_we;
  logic [5:0]    cfg_stream;
  logic [NR-1:0] cfg_mask;
  logic          flush;
  logic          m_load_state, m_new_stream_id, m_char_vld, m_eop, busy, err_orphan;
  logic [5:0]    m_stream_id;
  logic [7:0]    m_char;
  logic [NR-1:0] m_enable;
  logic [31:0]   stat_pkts, stat_bytes;

  dpi_pkt_sequencer #(.NUM_REGEX(NR), .MATCH_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_stream_id(in_stream_id),
    .cfg_we(cfg_we), .cfg_stream(cfg_stream), .cfg_mask(cfg_mask), .flush(flush),
    .m_load_state(m_load_state), .m_new_stream_id(m_new_stream_id),
    .m_stream_id(m_stream_id), .m_char(m_char), .m_char_vld(m_char_vld),
    .m_eop(m_eop), .m_enable(m_enable), .busy(busy), .err_orphan(err_orphan),
    .stat_pkts(stat_pkts), .stat_bytes(stat_bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  // Expected per-cycle outputs, keyed by cycle number.
  bit          exp_vld [int];
  logic [7:0]  exp_chr [int];
  bit          exp_ld  [int];
  bit          exp_new [int];
  bit          exp_eop [int];
  bit          exp_orph[int];
  bit          exp_rdy [int];
  logic [15:0] exp_en  [int];
  logic [5:0]  exp_id  [int];

  // Abstract stream state.
  bit          seen_m[64];
  logic [15:0] mask_m[64];
  bit          pend_m;
  int          pkts_m, bytes_m;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("char_vld", 32'(m_char_vld), 32'(exp_vld.exists(cyc)));
      if (exp_vld.exists(cyc)) chk("char", 32'(m_char), 32'(exp_chr[cyc]));
      chk("load_state", 32'(m_load_state), 32'(exp_ld.exists(cyc)));
      if (exp_ld.exists(cyc)) chk("new_stream_id", 32'(m_new_stream_id), 32'(exp_new[cyc]));
      chk("eop", 32'(m_eop), 32'(exp_eop.exists(cyc)));
      chk("err_orphan", 32'(err_orphan), 32'(exp_orph.exists(cyc)));
      chk("busy", 32'(busy), 32'(exp_en.exists(cyc)));
      if (exp_en.exists(cyc)) begin
        chk("enable", 32'(m_enable), 32'(exp_en[cyc]));
        chk("stream_id", 32'(m_stream_id), 32'(exp_id[cyc]));
      end
      if (exp_rdy.exists(cyc)) chk("in_ready", 32'(in_ready), 32'(exp_rdy[cyc]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark(input int c, input logic [15:0] en, input logic [5:0] id);
    exp_en[c] = en;
    exp_id[c] = id;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 64; i++) seen_m[i] = 1'b0;
  endtask

  task automatic cfg_write(input logic [5:0] id, input logic [15:0] val);
    cfg_we = 1'b1; cfg_stream = id; cfg_mask = val;
    mask_m[id] = val;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    clear_seen();
    step();
    flush = 1'b0;
  endtask

  task automatic orphan(input logic [7:0] d);
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = d;
    exp_rdy[cyc]    = 1'b1;
    exp_orph[cyc+1] = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // One packet; optional cfg write to this stream and/or flush on beat act_beat.
  task automatic send_pkt(input logic [5:0] id, input int len, input int gmax,
                          input int act_beat, input bit act_cfg, input logic [15:0] act_val,
                          input bit act_flush);
    logic [7:0]  b;
    logic [15:0] en;
    int          a, e;
    en = mask_m[id];
    exp_ld[cyc+1]  = 1'b1;
    exp_new[cyc+1] = !seen_m[id];
    seen_m[id] = 1'b1;
    b = 8'($urandom);
    in_valid = 1'b1; in_sop = 1'b1; in_eop = (len == 1); in_data = b; in_stream_id = id;
    for (int k = 0; k < 3; k++) begin
      exp_rdy[cyc] = 1'b0;
      mark(cyc + 1, en, id);
      step();
    end
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(0, gmax)) begin
          in_valid = 1'b0; in_sop = 1'($urandom); in_stream_id = 6'($urandom);
          mark(cyc + 1, en, id);
          step();
        end
        b = 8'($urandom);
        in_valid = 1'b1; in_sop = 1'($urandom); in_eop = (i == len - 1);
        in_data = b; in_stream_id = 6'($urandom);
      end
      if (i == act_beat) begin
        if (act_cfg) begin
          cfg_we = 1'b1; cfg_stream = id; cfg_mask = act_val;
          mask_m[id] = act_val;
        end
        if (act_flush) begin
          flush  = 1'b1;
          pend_m = 1'b1;
        end
      end
      exp_rdy[cyc]   = 1'b1;
      exp_vld[cyc+1] = 1'b1;
      exp_chr[cyc+1] = b;
      mark(cyc + 1, en, id);
      bytes_m++;
      step();
      cfg_we = 1'b0; flush = 1'b0;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    a = cyc - 1;
    e = a + LAT + 2;
    for (int c = a + 2; c <= e; c++) mark(c, en, id);
    exp_eop[e] = 1'b1;
    while (cyc <= e) step();
    pkts_m++;
    if (pend_m) begin
      clear_seen();
      pend_m = 1'b0;
    end
  endtask

  task automatic check_stats();
    @(negedge clk);
`ifdef DPI_SEQ_STATS_EN
    chk("stat_pkts", stat_pkts, 32'(pkts_m));
    chk("stat_bytes", stat_bytes, 32'(bytes_m));
`else
    chk("stat_pkts_off", stat_pkts, 32'd0);
    chk("stat_bytes_off", stat_bytes, 32'd0);
`endif
  endtask

  task automatic check_all_zero();
    chk("rst_load", 32'(m_load_state), 32'd0);
    chk("rst_new", 32'(m_new_stream_id), 32'd0);
    chk("rst_sid", 32'(m_stream_id), 32'd0);
    chk("rst_char", 32'(m_char), 32'd0);
    chk("rst_vld", 32'(m_char_vld), 32'd0);
    chk("rst_eop", 32'(m_eop), 32'd0);
    chk("rst_en", 32'(m_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_orphan", 32'(err_orphan), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_spkts", stat_pkts, 32'd0);
    chk("rst_sbytes", stat_bytes, 32'd0);
  endtask

  task automatic model_reset();
    clear_seen();
    for (int i = 0; i < 64; i++) mask_m[i] = '0;
    pend_m = 1'b0; pkts_m = 0; bytes_m = 0;
  endtask

  initial begin
    logic [5:0] id;
    int         len, ab;
    rst_n = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; in_stream_id = '0;
    cfg_we = 1'b0; cfg_stream = '0; cfg_mask = '0; flush = 1'b0;
    model_reset();
    repeat (3) step();
    @(negedge clk);
    check_all_zero();
    step();
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Directed scenarios.
    cfg_write(6'd5, 16'h0003);
    send_pkt(6'd5, 4, 0, -1, 1'b0, '0, 1'b0);
    check_stats();
    send_pkt(6'd5, 3, 1, -1, 1'b0, '0, 1'b0);
    do_flush();
    send_pkt(6'd5, 2, 0, -1, 1'b0, '0, 1'b0);
    send_pkt(6'd63, 1, 0, -1, 1'b0, '0, 1'b0);
    step();
    orphan(8'hAA);
    step();
    send_pkt(6'd5, 5, 0, 2, 1'b1, 16'hBEEF, 1'b1);
    send_pkt(6'd5, 2, 0, -1, 1'b0, '0, 1'b0);
    check_stats();

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: cfg_write(6'($urandom_range(0, 3) == 0 ? 63 : $urandom_range(0, 7)), 16'($urandom));
        1: do_flush();
        2: orphan(8'($urandom));
        default: begin
          id  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
          len = $urandom_range(1, 6);
          ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
          send_pkt(id, len, 2, ab, 1'($urandom), 16'($urandom), 1'($urandom));
        end
      endcase
      repeat ($urandom_range(0, 2)) step();
    end
    check_stats();

    // Reset mid-STREAM abandons the packet without a finalize.
    chk_on = 1'b0;
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_stream_id = 6'd9; in_data = 8'h11;
    repeat (5) step();
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
    step();
    @(negedge clk);
    check_all_zero();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_eop", 32'(m_eop), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_vld", 32'(m_char_vld), 32'd0);
      step();
    end
    model_reset();
    exp_vld.delete(); exp_chr.delete(); exp_ld.delete(); exp_new.delete(); exp_eop.delete();
    exp_orph.delete(); exp_rdy.delete(); exp_en.delete(); exp_id.delete();
    chk_on = 1'b1;

    for (int p = 0; p < 3; p++) send_pkt(6'd17, 10, 0, -1, 1'b0, '0, 1'b0);
    check_stats();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
